// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Round-robin arbiter and sequencer in front of one shared, purely
//   combinational barrel-shifter/reverser. Each issue slot grants one pending
//   requester, steers its fields onto the datapath and captures sh_y into a
//   one-deep result register that drains on a valid/ready handshake.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req_a/req_amt/req_rev per-requester operand, shift amount, reverse select
//   sh_a/sh_amt/sh_s      drive the shared datapath
//   sh_y                  datapath result (combinational from sh_*)
//   rsp_valid/rsp_ready   result handshake
//   rsp_data/rsp_id       registered result and the requester that produced it
module shift_arbiter #(
    parameter  int N    = 3,
    parameter  int NREQ = 4,
    localparam int W    = 2 ** N,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*N-1:0] req_amt,
    input  logic [NREQ-1:0]   req_rev,
    output logic [W-1:0]      sh_a,
    output logic [N-1:0]      sh_amt,
    output logic              sh_s,
    input  logic [W-1:0]      sh_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IW-1:0]     rsp_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic                found;
    logic                issue;
    logic                grant;

    logic [NREQ-1:0][W-1:0] a_arr;
    logic [NREQ-1:0][N-1:0] amt_arr;

    // Unflatten the per-requester operand buses.
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign a_arr[g]   = req_a[g*W +: W];
        assign amt_arr[g] = req_amt[g*N +: N];
    end

    // Rotating priority search starting at ptr. NREQ is a power of two, so
    // IW-bit addition wraps modulo NREQ for free. When nothing is valid, win
    // stays at ptr so the datapath still sees a defined requester's fields.
    always_comb begin
        logic [IW-1:0] idx;
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Issue slot: register free, or being drained this very cycle.
    assign issue = (state == EMPTY) || rsp_ready;
    assign grant = issue && found && !reset;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    // Datapath steering depends only on req_valid and ptr, never on rsp_ready.
    assign sh_a   = a_arr[win];
    assign sh_amt = amt_arr[win];
    assign sh_s   = req_rev[win];

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (issue) begin
            if (found) begin
                state    <= FULL;
                rsp_data <= sh_y;
                rsp_id   <= win;
                ptr      <= win + IW'(1);
            end else begin
                state    <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int N    = 3;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*N-1:0] req_amt;
    logic [NREQ-1:0]   req_rev;
    logic [W-1:0]      sh_a;
    logic [N-1:0]      sh_amt;
    logic              sh_s;
    logic [W-1:0]      sh_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IW-1:0]     rsp_id;

    logic [W-1:0] fa   [NREQ];
    logic [N-1:0] famt [NREQ];

    int nchk  = 0;
    int nfail = 0;

    // model state
    bit          m_full;
    int          m_ptr;
    logic [7:0]  m_data;
    int          m_id;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*W +: W]   = fa[g];
        assign req_amt[g*N +: N] = famt[g];
    end

    // Right shift with zero fill, then optional bit reversal.
    function automatic logic [7:0] ref_y(logic [7:0] a, int amt, logic rev);
        logic [7:0] v, r;
        v = a >> amt;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return rev ? r : v;
    endfunction

    // external shared datapath
    assign sh_y = ref_y(sh_a, int'(sh_amt), sh_s);

    shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_amt(req_amt), .req_rev(req_rev),
        .sh_a(sh_a), .sh_amt(sh_amt), .sh_s(sh_s), .sh_y(sh_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [3:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Called right after inputs are driven at a falling edge. Checks the
    // combinational grant, advances the model across the rising edge and
    // checks the registered outputs; returns at the next falling edge.
    task automatic step(output logic [3:0] rr);
        int w;
        bit issue;
        logic [3:0] exp_rr;
        #1;
        issue  = !m_full || rsp_ready;
        w      = pick(req_valid, m_ptr);
        exp_rr = (!reset && issue && w >= 0) ? 4'(1 << w) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        rr = req_ready;
        @(posedge clk);
        if (reset) begin
            m_full = 0; m_ptr = 0; m_data = 0; m_id = 0;
        end else if (issue) begin
            if (w >= 0) begin
                m_full = 1;
                m_data = ref_y(fa[w], int'(famt[w]), req_rev[w]);
                m_id   = w;
                m_ptr  = (w + 1) % NREQ;
            end else begin
                m_full = 0;
            end
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic       rev;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t       vt[5];
        logic [3:0] rr;
        logic [7:0] held_data;
        logic [1:0] held_id;

        vt[0] = '{8'hB2, 3'd3, 1'b0, 8'h16};
        vt[1] = '{8'hB2, 3'd3, 1'b1, 8'h68};
        vt[2] = '{8'h80, 3'd7, 1'b0, 8'h01};
        vt[3] = '{8'h5A, 3'd0, 1'b0, 8'h5A};
        vt[4] = '{8'h01, 3'd0, 1'b1, 8'h80};

        reset = 1; req_valid = 0; req_rev = 0; rsp_ready = 0;
        for (int i = 0; i < NREQ; i++) begin fa[i] = 0; famt[i] = 0; end
        m_full = 0; m_ptr = 0; m_data = 0; m_id = 0;
        @(negedge clk);
        step(rr);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        reset = 0;

        // single-request vectors on requester 2
        for (int v = 0; v < 5; v++) begin
            req_valid = 4'b0100; fa[2] = vt[v].a; famt[2] = vt[v].amt;
            req_rev = 4'b0; req_rev[2] = vt[v].rev; rsp_ready = 1;
            step(rr);
            chk("vec_grant", 32'(rr), 32'h4);
            chk("vec_data", 32'(rsp_data), 32'(vt[v].exp));
            chk("vec_id", 32'(rsp_id), 32'd2);
            req_valid = 0;
            step(rr);
            chk("vec_drain", 32'(rsp_valid), 32'd0);
        end

        // fairness with everybody valid, from a fresh pointer
        reset = 1; step(rr); reset = 0;
        for (int i = 0; i < NREQ; i++) begin
            fa[i] = 8'(8'h11 * (i + 1)); famt[i] = 3'(i);
        end
        req_rev = 4'b1010; req_valid = 4'hF; rsp_ready = 1;
        for (int k = 0; k < 6; k++) begin
            step(rr);
            chk("rr_grant", 32'(rr), 32'(1 << (k % 4)));
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
        end

        // backpressure: hold while FULL
        rsp_ready = 0;
        held_data = rsp_data; held_id = rsp_id;
        for (int k = 0; k < 5; k++) begin
            step(rr);
            chk("stall_grant", 32'(rr), 32'd0);
            chk("stall_data", 32'(rsp_data), 32'(held_data));
            chk("stall_id", 32'(rsp_id), 32'(held_id));
        end
        rsp_ready = 1;
        step(rr);
        chk("unstall_grant", 32'(rr), 32'h4);
        chk("unstall_id", 32'(rsp_id), 32'd2);

        // reset while FULL with requests pending
        reset = 1;
        step(rr);
        chk("rst_grant", 32'(rr), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        reset = 0; req_valid = 4'b0110;
        step(rr);
        chk("post_rst_grant", 32'(rr), 32'h2);

        // drive ptr to 3, then only req 1 valid: wrap to 1, ptr becomes 2
        req_valid = 4'b0100;
        step(rr);
        chk("to_ptr3", 32'(rr), 32'h4);
        req_valid = 4'b0010;
        step(rr);
        chk("wrap_grant", 32'(rr), 32'h2);
        req_valid = 4'hF;
        step(rr);
        chk("after_wrap", 32'(rr), 32'h4);

        // randomized traffic honoring the hold-while-pending rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || rr[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    fa[i]        = 8'($urandom);
                    famt[i]      = 3'($urandom);
                    req_rev[i]   = 1'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 59) == 0);
            step(rr);
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one barrel-shifter/reverser datapath among `NREQ` requesters. It picks one pending request per issue slot and drives the datapath's operand, amount and reverse inputs. It captures the datapath output into a result register and presents that result downstream on a valid/ready handshake, tagged with the requester index. It sits between the requesting units and the shared shifter/reverser instance, which stays purely combinational.

## Interface
- `N`, 3, log2 of data width; data width W = 2**N, shift amount width N
- `NREQ`, 4, number of requesters (power of two, 2..8); ID width `IW` = log2(NREQ)
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  request i pending
- `req_ready`  out  NREQ  request i accepted this cycle (one-hot or zero)
- `req_a`  in  NREQ*W  operand, requester i in bits [i*W +: W]
- `req_amt`  in  NREQ*N  right-shift amount, requester i in [i*N +: N]
- `req_rev`  in  NREQ  reverse-after-shift select per requester
- `sh_a`  out  W  to shared datapath operand
- `sh_amt`  out  N  to shared datapath shift amount
- `sh_s`  out  1  to shared datapath reverse select
- `sh_y`  in  W  from shared datapath, combinational function of sh_a/sh_amt/sh_s
- `rsp_valid`  out  1  result register holds a result
- `rsp_ready`  in  1  downstream accepts result
- `rsp_data`  out  W  registered result
- `rsp_id`  out  IW  index of requester that produced rsp_data

## Operation
- Datapath contract: sh_y = sh_s ? bitreverse(sh_a >> sh_amt) : (sh_a >> sh_amt). Logical shift, zero fill. The block relies only on this.
- States: EMPTY (result register free), FULL (rsp_valid=1).
- Issue slot exists when state is EMPTY, or when state is FULL and rsp_ready=1 (drain-and-refill in the same cycle).
- Arbitration: round-robin pointer `ptr` (IW bits). Winner is the first i with req_valid[i]=1, searching ptr, ptr+1, …, wrapping mod NREQ.
- In an issue slot with a winner w: req_ready[w]=1. sh_a/sh_amt/sh_s carry requester w's fields. At the clock edge, rsp_data<=sh_y, rsp_id<=w, state->FULL, ptr<=(w+1) mod NREQ.
- Issue slot with no valid request: FULL+rsp_ready goes to EMPTY, EMPTY stays EMPTY. ptr is unchanged.
- FULL and rsp_ready=0: hold. rsp_data, rsp_id and rsp_valid stay stable. req_ready is all zero. ptr is unchanged.
- When no winner exists, sh_a/sh_amt/sh_s carry requester ptr's fields. Their value is don't-care but must be X-free.
- A requester must hold its fields stable while req_valid is high and not accepted. Dropping valid before acceptance is allowed, and the request is then not served.

## Timing
- Reset (synchronous, dominates all other inputs): state=EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0. Reset mid-operation discards any held result, and no handshake completes in the reset cycle.
- req_ready is combinational from req_valid, state, ptr and rsp_ready. No other output depends combinationally on rsp_ready.
- Latency: accept in cycle t, rsp_valid=1 with the result from cycle t+1.
- Throughput: one result per cycle while rsp_ready stays high and requests are pending.
- Fairness: with all requesters continuously valid, each is granted exactly once in every NREQ consecutive issue slots.
- rsp_valid never drops without rsp_ready=1 in the prior cycle.
- Target size: 150-250 lines RTL, one always_ff plus a combinational arbiter.

## Test plan
- Reset, then N=3, req 2 only: a=0xB2, amt=3, rev=0 -> req_ready=0b0100 for one cycle; next cycle rsp_valid=1, rsp_data=0x16, rsp_id=2.
- Same request with rev=1 -> rsp_data=0x68. Second case: a=0x80, amt=7, rev=0 -> 0x01. Third case: amt=0, rev=0 -> data passes unchanged.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, with rsp_id following the same sequence one cycle later.
- rsp_ready=0 for 5 cycles while FULL and all requesters valid -> rsp_data/rsp_id stable, req_ready=0. When rsp_ready rises, a new grant is issued in the same cycle and the new result appears next cycle.
- Assert reset while FULL with requests pending -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0. The first grant after reset goes to the lowest valid index.
- ptr=3 with only req 1 valid -> grant 1 after wrap, then ptr=2.
